scs8hd_aoi_pipe: RTL



---
 rtl/scs8hd_aoi_pkg.sv | 24 ++
 rtl/scs8hd_aoi_pipe_stage.sv | 42 ++++
 rtl/scs8hd_aoi_pipe.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/scs8hd_aoi_pkg.sv
// Shared types and constants for the pipelined AND-OR-INVERT channel array.
// Used by scs8hd_aoi_pipe; see that file for the SCS8HD_AOI_TOGGLE_CNT_EN option.
package scs8hd_aoi_pkg;

  typedef enum logic [1:0] {
    AOI  = 2'b00,
    AO   = 2'b01,
    OAI  = 2'b10,
    RSVD = 2'b11
  } aoi_mode_e;

  localparam int TOGGLE_CNT_W = 16;
  localparam logic [TOGGLE_CNT_W-1:0] TOGGLE_CNT_MAX = 16'hFFFF;

  localparam int CHANNELS_MIN  = 1;
  localparam int CHANNELS_MAX  = 32;
  localparam int AND_WIDTH_MIN = 2;
  localparam int AND_WIDTH_MAX = 4;
  localparam int OR_WIDTH_MIN  = 1;
  localparam int OR_WIDTH_MAX  = 3;
  localparam int STAGES_MIN    = 1;
  localparam int STAGES_MAX    = 4;

endpackage

// File: rtl/scs8hd_aoi_pipe_stage.sv
// One valid/ready register slot; loads on ld_i, otherwise holds its contents.
// Data only updates when a valid word arrives, so the last result stays on the output when empty.
module scs8hd_aoi_pipe_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ld_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o
);

  logic             vld_d, vld_q;
  logic [WIDTH-1:0] data_d, data_q;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (ld_i) begin
      vld_d = vld_i;
      if (vld_i) begin
        data_d = data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/scs8hd_aoi_pipe.sv
// CHANNELS independent AOI/AO/OAI gates feeding a STAGES-deep valid/ready pipeline.
// Define SCS8HD_AOI_TOGGLE_CNT_EN to add per-channel delivered-output toggle counters.
module scs8hd_aoi_pipe
  import scs8hd_aoi_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int AND_WIDTH = 3,
  parameter int OR_WIDTH  = 2,
  parameter int STAGES    = 2
) (
  input  logic                          CLK,
  input  logic                          RESETB,
  input  logic                          IN_VALID,
  output logic                          IN_READY,
  input  logic [CHANNELS*AND_WIDTH-1:0] A,
  input  logic [CHANNELS*OR_WIDTH-1:0]  B,
  input  logic [1:0]                    MODE,
  output logic [CHANNELS-1:0]           Y,
  output logic                          OUT_VALID,
  input  logic                          OUT_READY,
  output logic                          BUSY
`ifdef SCS8HD_AOI_TOGGLE_CNT_EN
  ,
  input  logic                              TOGGLE_CLR,
  output logic [CHANNELS*TOGGLE_CNT_W-1:0]  TOGGLE_CNT
`endif
);

  if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX ||
      AND_WIDTH < AND_WIDTH_MIN || AND_WIDTH > AND_WIDTH_MAX ||
      OR_WIDTH < OR_WIDTH_MIN || OR_WIDTH > OR_WIDTH_MAX ||
      STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_param
    $error("scs8hd_aoi_pipe: parameter out of range");
  end

  function automatic logic eval_ch(input logic [AND_WIDTH-1:0] a,
                                   input logic [OR_WIDTH-1:0]  b,
                                   input aoi_mode_e            m);
    case (m)
      AO:      return (&a) | (|b);
      OAI:     return ~((|a) & (&b));
      default: return ~((&a) | (|b));
    endcase
  endfunction

  logic [CHANNELS-1:0] y_eval;

  always_comb begin
    y_eval = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      y_eval[ch] = eval_ch(A[ch*AND_WIDTH +: AND_WIDTH],
                           B[ch*OR_WIDTH +: OR_WIDTH],
                           aoi_mode_e'(MODE));
    end
  end

  logic [STAGES-1:0]   vld_q;
  logic [STAGES-1:0]   rdy;
  logic [CHANNELS-1:0] data_q [STAGES];

  // Stage k can load unless it and every stage after it are full with the sink stalled;
  // this is the unrolled form of ready_k = ~valid_k | ready_(k+1).
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                up_vld;
    logic [CHANNELS-1:0] up_data;

    assign rdy[k] = OUT_READY | ~(&vld_q[STAGES-1:k]);

    if (k == 0) begin : g_head
      assign up_vld  = IN_VALID;
      assign up_data = y_eval;
    end else begin : g_body
      assign up_vld  = vld_q[k-1];
      assign up_data = data_q[k-1];
    end

    scs8hd_aoi_pipe_stage #(
      .WIDTH (CHANNELS)
    ) u_stage (
      .clk_i  (CLK),
      .rst_ni (RESETB),
      .ld_i   (rdy[k]),
      .vld_i  (up_vld),
      .data_i (up_data),
      .vld_o  (vld_q[k]),
      .data_o (data_q[k])
    );
  end

  assign IN_READY  = rdy[0];
  assign OUT_VALID = vld_q[STAGES-1];
  assign Y         = data_q[STAGES-1];
  assign BUSY      = |vld_q;

`ifdef SCS8HD_AOI_TOGGLE_CNT_EN
  function automatic logic [TOGGLE_CNT_W-1:0] sat_inc(input logic [TOGGLE_CNT_W-1:0] c);
    return (c == TOGGLE_CNT_MAX) ? c : c + TOGGLE_CNT_W'(1);
  endfunction

  logic                    deliver;
  logic [CHANNELS-1:0]     prev_d, prev_q;
  logic [TOGGLE_CNT_W-1:0] cnt_d [CHANNELS];
  logic [TOGGLE_CNT_W-1:0] cnt_q [CHANNELS];

  assign deliver = OUT_VALID & OUT_READY;

  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    if (TOGGLE_CLR) begin
      prev_d = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        cnt_d[ch] = '0;
      end
    end else if (deliver) begin
      prev_d = Y;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (Y[ch] != prev_q[ch]) begin
          cnt_d[ch] = sat_inc(cnt_q[ch]);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      prev_q <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        cnt_q[ch] <= '0;
      end
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_cnt_out
    assign TOGGLE_CNT[ch*TOGGLE_CNT_W +: TOGGLE_CNT_W] = cnt_q[ch];
  end
`endif

endmodule
